alu_cmd_queue: RTL and testbench

//  Upstream command stage for SimpleALU. Buffers {opcode,a,b} commands from a valid/ready producer
//  in a DEPTH-entry FIFO and drives the queue head onto the combinational ALU inputs.

---
 rtl/alu_cmd_queue.sv | 110 +++++++++++
 tb/tb_alu_cmd_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - command FIFO and result register in front of SimpleALU (optional ALU_CMD_STATS_EN)
module alu_cmd_queue #(
  parameter int W     = 4,
  parameter int OPW   = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [OPW-1:0]             io_in_opcode,
  input  logic [W-1:0]               io_in_a,
  input  logic [W-1:0]               io_in_b,
  output logic [OPW-1:0]             io_alu_opcode,
  output logic [W-1:0]               io_alu_a,
  output logic [W-1:0]               io_alu_b,
  input  logic [W-1:0]               io_alu_out,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [W-1:0]               io_out_bits,
`ifdef ALU_CMD_STATS_EN
  output logic [15:0]                io_done_count,
`endif
  output logic [$clog2(DEPTH):0]     io_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OPW + 2 * W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           out_valid;
  logic [W-1:0]   out_bits;
  logic           not_empty;
  logic           fire_in;
  logic           issue;
  logic [EW-1:0]  head;

  assign not_empty = (count != '0);
  // Ready depends only on occupancy and the reset pin, never on in_valid/out_ready.
  assign io_in_ready = reset & (count != FULL_CNT);
  assign fire_in     = io_in_valid & io_in_ready;
  assign issue       = not_empty & (~out_valid | io_out_ready);
  assign head        = mem[rd_ptr];

  assign io_alu_opcode = not_empty ? head[EW-1 -: OPW] : '0;
  assign io_alu_a      = not_empty ? head[2*W-1 -: W]  : '0;
  assign io_alu_b      = not_empty ? head[W-1:0]       : '0;

  assign io_out_valid = out_valid;
  assign io_out_bits  = out_bits;
  assign io_count     = count;

  always_ff @(posedge clock) begin
    if (fire_in) begin
      mem[wr_ptr] <= {io_in_opcode, io_in_a, io_in_b};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire_in) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fire_in, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_bits  <= io_alu_out;
    end else if (io_out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_CMD_STATS_EN
  logic [15:0] done_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_count <= '0;
    end else if (out_valid & io_out_ready) begin
      done_count <= done_count + 16'd1;
    end
  end

  assign io_done_count = done_count;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - directed bench for alu_cmd_queue with a SimpleALU model downstream
module tb_alu_cmd_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_opcode;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bits;
  logic [2:0] count;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] done_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  alu_cmd_queue #(.W(4), .OPW(2), .DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_in_valid   (in_valid),
    .io_in_ready   (in_ready),
    .io_in_opcode  (in_opcode),
    .io_in_a       (in_a),
    .io_in_b       (in_b),
    .io_alu_opcode (alu_opcode),
    .io_alu_a      (alu_a),
    .io_alu_b      (alu_b),
    .io_alu_out    (alu_out),
    .io_out_valid  (out_valid),
    .io_out_ready  (out_ready),
    .io_out_bits   (out_bits),
`ifdef ALU_CMD_STATS_EN
    .io_done_count (done_count),
`endif
    .io_count      (count)
  );

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    alu_ref = a + b;
      2'd1:    alu_ref = a - b;
      2'd2:    alu_ref = a;
      default: alu_ref = b;
    endcase
  endfunction

  // SimpleALU stand-in: combinational op0=add, op1=sub, op2=a, op3=b
  always_comb begin
    alu_out = alu_ref(alu_opcode, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0] bp_exp[5];
    int sent, got, bubbles;
    bit started;

    vecs[0] = '{2'd0, 4'h3, 4'h4, 4'h7};
    vecs[1] = '{2'd1, 4'h2, 4'h5, 4'hD};
    vecs[2] = '{2'd0, 4'hF, 4'h1, 4'h0};
    vecs[3] = '{2'd2, 4'h9, 4'h6, 4'h9};
    vecs[4] = '{2'd3, 4'h9, 4'h6, 4'h6};
    vecs[5] = '{2'd1, 4'h0, 4'h1, 4'hF};

    reset = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step();
    step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_bits", out_bits, 0);
    chk("reset_count", count, 0);
    chk("reset_alu_a", alu_a, 0);
    reset = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);

    // single commands through an empty queue, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_opcode = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_count1", i), count, 1);
      chk($sformatf("v%0d_no_bypass", i), out_valid, 0);
      chk($sformatf("v%0d_alu_head", i), {alu_opcode, alu_a, alu_b}, {vecs[i].op, vecs[i].a, vecs[i].b});
      step();
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_out_bits", i), out_bits, vecs[i].exp);
      chk($sformatf("v%0d_count0", i), count, 0);
      chk($sformatf("v%0d_alu_idle", i), {alu_opcode, alu_a, alu_b}, 0);
      step();
      chk($sformatf("v%0d_drained", i), out_valid, 0);
      chk($sformatf("v%0d_bits_hold", i), out_bits, vecs[i].exp);
    end

    // backpressure: five pushes, one lands in the result register
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_exp[i] = alu_ref(2'd0, 4'(i + 2), 4'h3);
      in_valid = 1'b1; in_opcode = 2'd0; in_a = 4'(i + 2); in_b = 4'h3;
      chk($sformatf("bp_ready%0d", i), in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    chk("bp_count_full", count, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_bits", out_bits, bp_exp[0]);
    step();
    chk("bp_hold_bits", out_bits, bp_exp[0]);
    chk("bp_hold_count", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_res_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_res_bits%0d", i), out_bits, bp_exp[i]);
      step();
    end
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_count", count, 0);

    // streaming 20 commands back to back
    sent = 0; got = 0; bubbles = 0; started = 0;
    for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
      in_valid = (sent < 20);
      in_opcode = 2'(sent % 4); in_a = 4'(sent); in_b = 4'(sent * 3);
      if (out_valid) begin
        chk($sformatf("st_bits%0d", got), out_bits, alu_ref(2'(got % 4), 4'(got), 4'(got * 3)));
        got++;
        started = 1;
      end else if (started) begin
        bubbles++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    chk("st_received", got, 20);
    chk("st_bubbles", bubbles, 0);
    step();
    chk("st_idle", out_valid, 0);

    // asynchronous reset with three queued commands and a pending result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_opcode = 2'd2; in_a = 4'(i + 8); in_b = 4'h0;
      step();
    end
    in_valid = 1'b0;
    chk("mr_count", count, 3);
    chk("mr_pending", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_count0", count, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_out_bits", out_bits, 0);
    #2;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mr_no_stale%0d", i), out_valid, 0);
      chk($sformatf("mr_count_stays%0d", i), count, 0);
    end
    chk("mr_ready_after", in_ready, 1);

`ifdef ALU_CMD_STATS_EN
    chk("stat_reset", done_count, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_opcode = 2'd0; in_a = 4'(i); in_b = 4'h1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stat_ten", done_count, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
